// File: rtl/int_arb.sv
// Interrupt arbiter: masked/in-service gating, fixed or round-robin selection, APB register file.
// Optional nesting (fixed-priority preemption from SERVICE) is compiled in with INT_ARB_NEST_EN.
module int_arb (
  input  logic        apb_pclk,
  input  logic        apb_prstn,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [19:0] apb_paddr,
  input  logic [7:0]  apb_pwdata,
  output logic [7:0]  apb_prdata,
  input  logic [7:0]  int_pend,
  output logic        cpu_irq,
  output logic [2:0]  cpu_vec,
  input  logic        cpu_ack
);

  localparam logic [19:0] ADDR_MASK = 20'h00000;
  localparam logic [19:0] ADDR_MODE = 20'h00004;
  localparam logic [19:0] ADDR_ISR  = 20'h00008;
  localparam logic [19:0] ADDR_EOI  = 20'h0000C;
  localparam logic [19:0] ADDR_VEC  = 20'h00010;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mask;
  logic        r_mode;
  logic        r_mode_act;
  logic [7:0]  r_isr;
  logic [2:0]  r_rr_ptr;
  logic [2:0]  r_vec;

  logic        w_wr;
  logic        w_wr_mask;
  logic        w_wr_mode;
  logic        w_wr_eoi;
  logic [7:0]  w_eoi_clr;
  logic        w_mode_eff;
  logic [7:0]  w_elig;
  logic [2:0]  w_fix_win;
  logic [2:0]  w_rr_win;
  logic        w_rr_hit;
  logic [2:0]  w_rr_idx;
  logic [2:0]  w_win_sel;
  logic        w_ack_ok;
  logic [7:0]  w_isr_clr;
  logic [7:0]  w_isr_nxt;
  logic        w_vec_live;
  logic        w_nest_req;
  logic        w_latch;

  assign w_wr      = apb_psel & apb_penable & apb_pwrite;
  assign w_wr_mask = w_wr && (apb_paddr == ADDR_MASK);
  assign w_wr_mode = w_wr && (apb_paddr == ADDR_MODE);
  assign w_wr_eoi  = w_wr && (apb_paddr == ADDR_EOI);
  assign w_eoi_clr = w_wr_eoi ? apb_pwdata : '0;

  // Mode follows the stored register while idle and is frozen otherwise, so a
  // write outside IDLE takes effect automatically on the next IDLE cycle.
  assign w_mode_eff = (r_state == S_IDLE) ? r_mode : r_mode_act;

  assign w_elig     = int_pend & r_mask & ~r_isr;
  assign w_ack_ok   = cpu_ack && (r_state == S_REQ);
  assign w_isr_clr  = r_isr & ~w_eoi_clr;
  assign w_isr_nxt  = w_isr_clr | (w_ack_ok ? (8'd1 << r_vec) : '0);
  assign w_vec_live = int_pend[r_vec] & r_mask[r_vec];

  always_comb begin
    w_fix_win = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_elig[7-i]) w_fix_win = 3'(7 - i);
    end
  end

  always_comb begin
    w_rr_win = '0;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_rr_idx = r_rr_ptr + 3'(i);
      if (!w_rr_hit && w_elig[w_rr_idx]) begin
        w_rr_win = w_rr_idx;
        w_rr_hit = 1'b1;
      end
    end
  end

`ifdef INT_ARB_NEST_EN
  logic [2:0] w_isr_low;

  always_comb begin
    w_isr_low = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r_isr[7-i]) w_isr_low = 3'(7 - i);
    end
  end

  assign w_nest_req = !w_mode_eff && (|w_elig) && (w_fix_win < w_isr_low);
`else
  assign w_nest_req = 1'b0;
`endif

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_ack_ok)        w_state_nxt = S_SERVICE;
        else if (!w_vec_live) w_state_nxt = (|w_isr_clr) ? S_SERVICE : S_IDLE;
      end
      S_SERVICE: begin
        if (w_isr_nxt == '0) w_state_nxt = S_IDLE;
        else if (w_nest_req) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_irq   = (r_state == S_REQ);
    cpu_vec   = r_vec;
    w_latch   = (r_state != S_REQ) && (w_state_nxt == S_REQ);
    w_win_sel = (r_state == S_IDLE && w_mode_eff) ? w_rr_win : w_fix_win;
    case (apb_paddr)
      ADDR_MASK: apb_prdata = r_mask;
      ADDR_MODE: apb_prdata = {7'b0, r_mode};
      ADDR_ISR:  apb_prdata = r_isr;
      ADDR_VEC:  apb_prdata = {cpu_irq, 4'b0, r_vec};
      default:   apb_prdata = '0;
    endcase
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_mask     <= '0;
      r_mode     <= 1'b0;
      r_mode_act <= 1'b0;
      r_isr      <= '0;
      r_rr_ptr   <= '0;
      r_vec      <= '0;
    end else begin
      r_mode_act <= w_mode_eff;
      r_isr      <= w_isr_nxt;
      if (w_wr_mask) r_mask   <= apb_pwdata;
      if (w_wr_mode) r_mode   <= apb_pwdata[0];
      if (w_ack_ok)  r_rr_ptr <= r_vec + 3'd1;
      if (w_latch)   r_vec    <= w_win_sel;
    end
  end

endmodule
